// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI counter receive path.
// Frame layout: byte0 = {2'b00, counter[13:8]}, byte1 = counter[7:0].
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1,
        DRAIN
    } rx_state_e;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned BYTE_BITS   = 8;
    localparam int unsigned HDR_BITS    = 2;
    localparam int unsigned BIT_CNT_MAX = 17;
    localparam logic [7:0]  SYNC_MARKER = 8'hA5;

    // A frame is accepted only with exactly FRAME_BITS bits and a zero header.
    function automatic logic frame_ok(input logic [4:0]            bit_cnt,
                                      input logic [FRAME_BITS-1:0] rx);
        return (bit_cnt == 5'(FRAME_BITS)) && (rx[FRAME_BITS-1 -: HDR_BITS] == '0);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, with rise/fall detection
// against a one-cycle-delayed copy of the synchronised level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        o_level = sync_q[SYNC_STAGES-1];
        o_rise  = o_level & ~prev_q;
        o_fall  = ~o_level & prev_q;
    end

endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave receive stage: rebuilds 16-bit frames into a counter value and
// returns a sync marker plus an echo of the previous frame's first byte on miso.
module spi_counter_rx
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic [DATA_W-1:0] o_counter,
    output logic              o_data_valid,
    output logic              o_frame_err
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (sclk),
        .o_level (sclk_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    // Select idles high, so its chain resets high to avoid a false fall out of reset.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ss (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (ss),
        .o_level (ss_level),
        .o_rise  (ss_rise),
        .o_fall  (ss_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (mosi),
        .o_level (mosi_level),
        .o_rise  (mosi_rise),
        .o_fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    rx_state_e             state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [7:0]            echo_q, echo_d;
    logic [DATA_W-1:0]     counter_q, counter_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic sclk_rise_sel, sclk_fall_sel;
    assign sclk_rise_sel = sclk_rise & ~ss_level;
    assign sclk_fall_sel = sclk_fall & ~ss_level;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        echo_d    = echo_q;
        counter_d = counter_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (ss_rise && (state_q != IDLE)) begin
            state_d = IDLE;
            if (frame_ok(bit_cnt_q, rx_q)) begin
                counter_d = rx_q[DATA_W-1:0];
                echo_d    = rx_q[FRAME_BITS-1 -: 8];
                valid_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_d   = BYTE0;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        tx_d      = {SYNC_MARKER, echo_q};
                    end
                end
                BYTE0, BYTE1: begin
                    if (sclk_rise_sel) begin
                        rx_d      = {rx_q[FRAME_BITS-2:0], mosi_level};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (state_q == BYTE0 && bit_cnt_d == 5'(BYTE_BITS)) begin
                            state_d = BYTE1;
                        end else if (state_q == BYTE1 && bit_cnt_d == 5'(FRAME_BITS)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Data is frozen; the count only moves so an over-long frame is flagged.
                    if (sclk_rise_sel && bit_cnt_q < 5'(BIT_CNT_MAX)) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (sclk_fall_sel && (state_q != IDLE)) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            echo_q    <= 8'h00;
            counter_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            echo_q    <= echo_d;
            counter_q <= counter_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign miso         = (state_q != IDLE) & tx_q[FRAME_BITS-1];
    assign o_counter    = counter_q;
    assign o_data_valid = valid_q;
    assign o_frame_err  = err_q;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Bench for spi_counter_rx: table of frames with constant expectations, a pulse
// scoreboard, and hand-written reset/unselected/back-to-back sequences.
module tb_spi_counter_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss = 1'b1;
    logic        miso;
    logic [13:0] o_counter;
    logic        o_data_valid;
    logic        o_frame_err;

    spi_counter_rx #(
        .SYNC_STAGES (2),
        .DATA_W      (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .mosi         (mosi),
        .ss           (ss),
        .miso         (miso),
        .o_counter    (o_counter),
        .o_data_valid (o_data_valid),
        .o_frame_err  (o_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [13:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic        is_err;
        logic [13:0] exp_cnt;
        logic [15:0] exp_miso;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   n_valid = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passes++;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: mosi changes while sclk is low, miso sampled just before each rise.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                              output logic [15:0] miso_bits);
        miso_bits = '0;
        ss = 1'b0;
        mosi = data[nbits-1];
        wait_clks(half);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) miso_bits[15-i] = miso;
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
            if (i + 1 < nbits) mosi = data[nbits-2-i];
            wait_clks(half);
        end
        ss = 1'b1;
        mosi = 1'b0;
    endtask

    // Scoreboard: every valid/error pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (o_data_valid || o_frame_err)) begin
            if (o_data_valid) n_valid++;
            if (o_frame_err) n_err++;
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected none",
                         o_data_valid, o_frame_err);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_kind", 32'({o_frame_err, o_data_valid}),
                    e.is_err ? 32'd2 : 32'd1);
                if (!e.is_err) chk("commit_value", 32'(o_counter), 32'(e.cnt));
            end
        end
    end

    vec_t        vecs[6];
    logic [15:0] mbits;
    int          snap_v;
    int          snap_e;
    int          t;

    initial begin
        vecs[0] = '{32'h0000_1ABC, 16, 1'b0, 14'h1ABC, 16'hA500};
        vecs[1] = '{32'h0000_0005, 16, 1'b0, 14'h0005, 16'hA51A};
        vecs[2] = '{32'h0000_3FFF, 16, 1'b0, 14'h3FFF, 16'hA500};
        vecs[3] = '{32'h0000_0ABC, 12, 1'b1, 14'h3FFF, 16'hA530};
        vecs[4] = '{32'h0000_1234, 18, 1'b1, 14'h3FFF, 16'hA53F};
        vecs[5] = '{32'h0000_C000, 16, 1'b1, 14'h3FFF, 16'hA53F};

        wait_clks(3);
        chk("reset_counter", 32'(o_counter), 32'd0);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_valid", 32'(o_data_valid), 32'd0);
        chk("reset_err", 32'(o_frame_err), 32'd0);
        reset = 1'b0;
        wait_clks(4);
        chk("idle_miso", 32'(miso), 32'd0);

        for (int v = 0; v < 6; v++) begin
            sb_q.push_back('{vecs[v].is_err, vecs[v].exp_cnt});
            send_frame(vecs[v].data, vecs[v].nbits, 5, mbits);
            chk($sformatf("miso_v%0d", v), 32'(mbits), 32'(vecs[v].exp_miso));
            wait_clks(2);
            chk($sformatf("pulse_early_v%0d", v),
                32'(vecs[v].is_err ? o_frame_err : o_data_valid), 32'd0);
            wait_clks(1);
            chk($sformatf("pulse_at3_v%0d", v),
                32'(vecs[v].is_err ? o_frame_err : o_data_valid), 32'd1);
            wait_clks(1);
            chk($sformatf("pulse_width_v%0d", v),
                32'(vecs[v].is_err ? o_frame_err : o_data_valid), 32'd0);
            chk($sformatf("counter_v%0d", v), 32'(o_counter), 32'(vecs[v].exp_cnt));
            wait_clks(4);
        end

        // Reset asserted 9 bits into a frame: outputs clear at once, frame is dropped.
        snap_v = n_valid;
        snap_e = n_err;
        ss = 1'b0;
        mosi = 1'b1;
        wait_clks(5);
        for (int i = 0; i < 9; i++) begin
            sclk = 1'b1;
            wait_clks(5);
            sclk = 1'b0;
            mosi = ~mosi;
            wait_clks(5);
        end
        sclk = 1'b1;
        wait_clks(2);
        reset = 1'b1;
        #1;
        chk("midreset_counter", 32'(o_counter), 32'd0);
        chk("midreset_miso", 32'(miso), 32'd0);
        chk("midreset_valid", 32'(o_data_valid), 32'd0);
        chk("midreset_err", 32'(o_frame_err), 32'd0);
        wait_clks(3);
        ss = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(8);
        chk("midreset_no_valid", 32'(n_valid), 32'(snap_v));
        chk("midreset_no_err", 32'(n_err), 32'(snap_e));

        sb_q.push_back('{1'b0, 14'h0123});
        send_frame(32'h0000_0123, 16, 5, mbits);
        chk("miso_after_reset", 32'(mbits), 32'hA500);
        wait_clks(6);
        chk("counter_after_reset", 32'(o_counter), 32'h0123);

        // sclk toggling while deselected must be invisible.
        snap_v = n_valid;
        snap_e = n_err;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom_range(1, 0));
            wait_clks(3);
        end
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clks(6);
        chk("unsel_no_valid", 32'(n_valid), 32'(snap_v));
        chk("unsel_no_err", 32'(n_err), 32'(snap_e));
        chk("unsel_counter", 32'(o_counter), 32'h0123);

        // Back-to-back frames at the minimum master timing.
        sb_q.push_back('{1'b0, 14'h2AAA});
        send_frame(32'h0000_2AAA, 16, 4, mbits);
        chk("miso_b2b_0", 32'(mbits), 32'hA501);
        wait_clks(4);
        sb_q.push_back('{1'b0, 14'h1555});
        send_frame(32'h0000_1555, 16, 4, mbits);
        chk("miso_b2b_1", 32'(mbits), 32'hA52A);

        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            wait_clks(1);
            t++;
        end
        wait_clks(4);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("b2b_valid_pulses", 32'(n_valid - snap_v), 32'd2);
        chk("final_counter", 32'(o_counter), 32'h1555);
        chk("total_valid", 32'(n_valid), 32'd6);
        chk("total_err", 32'(n_err), 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish within 2 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_counter_rx.md
# spi_counter_rx

Slave-side SPI receive stage that sits directly downstream of the on-board SPI link. It synchronises the externally clocked `sclk`, `mosi` and `ss` into the `clk` domain and reassembles 16-bit frames into a 14-bit counter value. It also returns a status/echo stream on `miso`. Its `o_counter` and `o_data_valid` outputs feed the FND display path.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per synchroniser; minimum 2.
- `DATA_W`, default 14: counter width. The frame layout below is fixed for 14.
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-high.
- `sclk`, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous to `clk`.
- `mosi`, input, 1: serial data from the master, MSB first.
- `ss`, input, 1: slave select, active-low.
- `miso`, output, 1: serial data to the master.
- `o_counter`, output, `DATA_W`: last successfully received counter value.
- `o_data_valid`, output, 1: one-`clk` pulse when `o_counter` is updated.
- `o_frame_err`, output, 1: one-`clk` pulse when a frame is rejected.

## Operation
- **Frame format:** `ss` low, 16 `sclk` cycles, then `ss` high.
  - Byte0 = {2'b00, counter[13:8]}.
  - Byte1 = counter[7:0].
- **Input capture:** `sclk`, `ss` and `mosi` each pass through a `SYNC_STAGES` synchroniser. Rising and falling edges of the synchronised `sclk` and `ss` are detected against a one-cycle-delayed copy.
- **Receive shift:** on each detected `sclk` rise while `ss` is low, shift the synchronised `mosi` into a 16-bit register and increment a 5-bit bit counter. The counter saturates at 17.
- **Transmit shift:** the tx register is loaded on detected `ss` fall. After each detected `sclk` fall, shift left by one.
  - `miso` = tx register MSB while `ss` is low, and 0 while `ss` is high.
  - Tx byte0 = 8'hA5, the sync marker.
  - Tx byte1 = the previous frame's received byte0 (echo). Its reset value is 8'h00.
- **State machine (IDLE, BYTE0, BYTE1, DRAIN):**
  - IDLE → BYTE0 on `ss` fall. This transition clears the bit counter and loads the tx register.
  - BYTE0 → BYTE1 after 8 rising edges.
  - BYTE1 → DRAIN after 16 rising edges.
  - DRAIN ignores further `sclk` edges but lets the bit counter reach 17.
  - Any state → IDLE on detected `ss` rise.
- **Commit, evaluated on `ss` rise:**
  - Commit when bit count = 16 and rx[15:14] = 2'b00. Then `o_counter` ← rx[13:0], `o_data_valid` pulses, and the echo byte ← rx[15:8].
  - Otherwise pulse `o_frame_err`. `o_counter` and the echo byte are unchanged. This covers short frames, over-long frames (count 17) and bad header bits.
- **Unselected activity:** `sclk` activity while `ss` is high is ignored, with no state change.
- **Reset values:** `miso` = 0, `o_counter` = 0, `o_data_valid` = 0, `o_frame_err` = 0, state = IDLE, echo byte = 8'h00. All synchroniser flops reset to 0, except the `ss` chain, which resets to 1.
- **Reset mid-frame:** the frame is discarded. No valid or error pulse is produced from that frame.

## Timing
- **Input latency:** a pin transition is seen as a detected edge `SYNC_STAGES` clk edges later. With the default of 2, that is 2 edges.
- **Commit latency:** `o_data_valid` and `o_frame_err` are registered. They go high on clk edge `SYNC_STAGES`+1 after the `ss` pin rise, and stay high for exactly 1 cycle.
- **Output hold:** `o_counter` changes on the same edge as the `o_data_valid` rise and holds until the next commit.
- **`miso` latency:** `miso` updates `SYNC_STAGES`+1 clk after the `sclk` pin fall. The first bit is valid `SYNC_STAGES`+1 clk after the `ss` pin fall.
- **Master requirements:**
  - `sclk` high and low times ≥ `SYNC_STAGES`+2 clk each, i.e. period ≥ 8 clk at the default.
  - ≥ `SYNC_STAGES`+2 clk from `ss` fall to the first `sclk` rise.
  - `ss` high for ≥ 4 clk between frames.
- **Back-to-back frames** meeting these minimums are all committed, one pulse each.

## Structure
- **Package `spi_pkg`:**
  - state enum `rx_state_e` {IDLE, BYTE0, BYTE1, DRAIN};
  - `FRAME_BITS` = 16;
  - `SYNC_MARKER` = 8'hA5;
  - `HDR_BITS` = 2.
- **Sub-module `sync_edge`:** `SYNC_STAGES`-deep synchroniser with a reset-value parameter, producing `o_level`, `o_rise` and `o_fall`.
  - Instantiated for `sclk` and `ss`.
  - `mosi` uses its `o_level` output only.

## Test plan
- **Good frame:** frame carrying 14'h1ABC (bytes 8'h1A, 8'hBC) at sclk = clk/10. Required:
  - `o_counter` = 14'h1ABC;
  - one `o_data_valid` pulse, 3 clk after `ss` rise;
  - `miso` bits = 8'hA5 then 8'h00.
- **Echo and max value:** two frames, 14'h0005 then 14'h3FFF. Required:
  - second frame's `miso` byte1 = 8'h00 (the echo of first byte0);
  - `o_counter` ends at 14'h3FFF;
  - two valid pulses.
- **Short frame:** `ss` released after 12 bits. Required: one `o_frame_err` pulse, no `o_data_valid`, `o_counter` unchanged.
- **Over-long and bad header:** an 18-bit frame, and separately a 16-bit frame with byte0 = 8'hC0. Required: `o_frame_err` pulse for each, `o_counter` unchanged.
- **Reset mid-frame:** assert `reset` after 9 bits. Required:
  - all outputs 0 immediately (asynchronous);
  - no pulses;
  - the next good frame (14'h0123) commits normally.
- **Unselected sclk:** `sclk` toggling with `ss` high, then a back-to-back pair of frames at minimum spacing. Required: no pulses during the unselected `sclk` activity, then exactly two valid pulses with the correct values.
